// File: rtl/mmio_bridge.sv
// CPU external memory port bridge: RAM/I-O address decode, I/O register page,
// prescaled timer with wrap status, and 1-cycle read data merge.
module mmio_bridge #(
  parameter logic [9:0]  IO_BASE  = 10'h3F0,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned SW_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_write_en,
  input  logic [9:0]          cpu_addr,
  input  logic [15:0]         cpu_data_in,
  output logic [15:0]         cpu_data_out,
  output logic                ram_we,
  output logic [9:0]          ram_addr,
  output logic [15:0]         ram_wdata,
  input  logic [15:0]         ram_rdata,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] leds,
  output logic [15:0]         hex_value,
  output logic                timer_irq
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

  localparam logic [3:0] OFF_LED    = 4'd0;
  localparam logic [3:0] OFF_SW     = 4'd1;
  localparam logic [3:0] OFF_HEX    = 4'd2;
  localparam logic [3:0] OFF_TCOUNT = 4'd3;
  localparam logic [3:0] OFF_TCTRL  = 4'd4;
  localparam logic [3:0] OFF_STATUS = 4'd5;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } tstate_e;

  tstate_e             state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [DATA_W-1:0]   tcount_q, tcount_d;
  logic                wrap_q, wrap_d;
  logic [DATA_W-1:0]   led_q, hex_q;
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic                io_sel_q;
  logic [DATA_W-1:0]   io_rdata_q;

  logic                io_sel_c;
  logic                io_wr_c;
  logic [3:0]          off_c;
  logic                tctrl_wr_c;
  logic                clear_c;
  logic                tick_c;
  logic [DATA_W-1:0]   io_rdata_c;

  // Address decode and RAM port pass-through
  always_comb begin
    io_sel_c   = (cpu_addr[9:4] == IO_BASE[9:4]);
    off_c      = cpu_addr[3:0];
    io_wr_c    = cpu_write_en & io_sel_c;
    tctrl_wr_c = io_wr_c & (off_c == OFF_TCTRL);
    clear_c    = tctrl_wr_c & cpu_data_in[1];
    ram_we     = cpu_write_en & ~io_sel_c;
    ram_addr   = cpu_addr;
    ram_wdata  = cpu_data_in;
  end

  // Timer state register (IDLE/RUN tracks the stored enable bit)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= T_IDLE;
    else        state_q <= state_d;
  end

  // Timer next state, prescaler, count and wrap status; clear beats tick, set beats W1C
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    tcount_d = tcount_q;
    wrap_d   = wrap_q;
    tick_c   = 1'b0;

    if (tctrl_wr_c) state_d = cpu_data_in[0] ? T_RUN : T_IDLE;

    if (state_q == T_RUN) begin
      if (pcnt_q == PCNT_MAX) begin
        tick_c = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
    end

    if (tick_c) tcount_d = tcount_q + DATA_W'(1);

    if (clear_c) begin
      pcnt_d   = '0;
      tcount_d = '0;
    end

    if (io_wr_c && (off_c == OFF_STATUS) && cpu_data_in[0]) wrap_d = 1'b0;
    if (tick_c && !clear_c && (tcount_q == 16'hFFFF))      wrap_d = 1'b1;
  end

  // Timer datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q   <= '0;
      tcount_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      tcount_q <= tcount_d;
      wrap_q   <= wrap_d;
    end
  end

  // LED/HEX writable registers and switch synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      hex_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      if (io_wr_c && (off_c == OFF_LED)) led_q <= cpu_data_in;
      if (io_wr_c && (off_c == OFF_HEX)) hex_q <= cpu_data_in;
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
    end
  end

  // I/O page read mux
  always_comb begin
    io_rdata_c = '0;
    case (off_c)
      OFF_LED:    io_rdata_c = led_q;
      OFF_SW:     io_rdata_c = DATA_W'(sw_s2_q);
      OFF_HEX:    io_rdata_c = hex_q;
      OFF_TCOUNT: io_rdata_c = tcount_q;
      OFF_TCTRL:  io_rdata_c = DATA_W'(state_q == T_RUN);
      OFF_STATUS: io_rdata_c = DATA_W'(wrap_q);
      default:    io_rdata_c = '0;
    endcase
  end

  // Register I/O read data to match the RAM's 1-cycle read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      io_sel_q   <= io_sel_c;
      io_rdata_q <= io_rdata_c;
    end
  end

  // Read data merge and board outputs
  always_comb begin
    cpu_data_out = io_sel_q ? io_rdata_q : ram_rdata;
    leds         = led_q[SW_WIDTH-1:0];
    hex_value    = hex_q;
    timer_irq    = wrap_q;
  end

endmodule
